// File: rtl/led_matrix_scan.sv
// Row-multiplexed 8x8 LED matrix driver with double-buffered board and inter-row blanking.
// A new board is latched into a pending buffer and swapped into display only at a frame boundary.
module led_matrix_scan #(
  parameter int DWELL_CYCLES   = 4,
  parameter int BLANK_CYCLES   = 1,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] frame_in,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic        frame_done,
  output logic        busy
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [7:0]    COL_MASK   = {8{COL_ACTIVE_LOW}};
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t        state_reg;
  logic [2:0]    row_reg;
  logic [CW-1:0] cnt_reg;
  logic [63:0]   pending_reg;
  logic [63:0]   display_reg;
  logic          pending_valid_reg;

  logic        accept;
  logic        row_end;
  logic        frame_end;
  logic        swap;
  logic        start_row;
  logic [63:0] display_next;
  logic [2:0]  row_next;
  logic [7:0]  onehot_next;
  logic [7:0]  col_next;
  logic [7:0]  row_bytes [8];

  assign frame_ready  = !pending_valid_reg;
  assign accept       = frame_valid && !pending_valid_reg;
  assign row_end      = (state_reg == DRIVE) && (cnt_reg == DWELL_LAST);
  assign frame_end    = row_end && (row_reg == 3'd7);
  // Swap decision uses the registered pending flag, so a board accepted this edge waits a frame.
  assign swap         = pending_valid_reg && ((state_reg == IDLE) || frame_end);
  assign start_row    = ((state_reg == IDLE) && swap) || row_end;
  assign display_next = swap ? pending_reg : display_reg;

  // Row about to be entered: IDLE starts at 0, DRIVE advances (wrapping), BLANK keeps its row.
  assign row_next = (state_reg == IDLE)  ? 3'd0 :
                    (state_reg == DRIVE) ? row_reg + 3'd1 : row_reg;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_row
      assign row_bytes[gi]   = display_next[8*gi +: 8];
      assign onehot_next[gi] = (row_next == 3'(gi));
    end
  endgenerate

  assign col_next = row_bytes[row_next] ^ COL_MASK;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg         <= IDLE;
      row_reg           <= 3'd0;
      cnt_reg           <= '0;
      pending_reg       <= 64'd0;
      display_reg       <= 64'd0;
      pending_valid_reg <= 1'b0;
      row_sel           <= 8'h00;
      col_data          <= COL_MASK;
      frame_done        <= 1'b0;
      busy              <= 1'b0;
    end else begin
      frame_done <= frame_end;

      if (accept) begin
        pending_reg       <= frame_in;
        pending_valid_reg <= 1'b1;
      end
      if (swap) begin
        display_reg       <= pending_reg;
        pending_valid_reg <= 1'b0;
      end

      if (start_row) begin
        row_reg <= row_next;
        cnt_reg <= '0;
        busy    <= 1'b1;
        if (BLANK_CYCLES > 0) begin
          state_reg <= BLANK;
          row_sel   <= 8'h00;
          col_data  <= COL_MASK;
        end else begin
          state_reg <= DRIVE;
          row_sel   <= onehot_next;
          col_data  <= col_next;
        end
      end else if (state_reg == BLANK) begin
        if (cnt_reg == BLANK_LAST) begin
          state_reg <= DRIVE;
          cnt_reg   <= '0;
          row_sel   <= onehot_next;
          col_data  <= col_next;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end else if (state_reg == DRIVE) begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Scoreboard bench for led_matrix_scan: stimulus queues expected row drives, monitors pop and compare.
// Second instance covers active-low columns with no blanking.
module tb_led_matrix_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, frame_valid, frame_ready, frame_done, busy;
  logic [63:0] frame_in;
  logic [7:0]  row_sel, col_data;
  logic        reset2, frame_valid2, frame_ready2, frame_done2, busy2;
  logic [63:0] frame_in2;
  logic [7:0]  row_sel2, col_data2;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_q2[$];

  led_matrix_scan dut (
    .clk(clk), .reset(reset), .frame_in(frame_in), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .row_sel(row_sel), .col_data(col_data),
    .frame_done(frame_done), .busy(busy)
  );

  led_matrix_scan #(.DWELL_CYCLES(4), .BLANK_CYCLES(0), .COL_ACTIVE_LOW(1'b1)) dut2 (
    .clk(clk), .reset(reset2), .frame_in(frame_in2), .frame_valid(frame_valid2),
    .frame_ready(frame_ready2), .row_sel(row_sel2), .col_data(col_data2),
    .frame_done(frame_done2), .busy(busy2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // cols lists the hand-computed column byte of row 0 first (MSB) through row 7 (LSB).
  task automatic push_frame(input logic [63:0] cols, input bit inv, input bit second);
    for (int r = 0; r < 8; r++) begin
      logic [7:0] c;
      logic [7:0] rs;
      c  = cols[63-8*r -: 8];
      rs = 8'h01 << r;
      if (inv) c = ~c;
      for (int k = 0; k < 4; k++) begin
        if (second) exp_q2.push_back({rs, c});
        else        exp_q.push_back({rs, c});
      end
    end
  endtask

  task automatic wait_fd(input bit second, input string name);
    int n;
    n = 0;
    tick;
    while (((second ? frame_done2 : frame_done) !== 1'b1) && n < 100) begin
      tick;
      n++;
    end
    if (n >= 100) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_row(input logic [7:0] rs, input string name);
    int n;
    n = 0;
    while (row_sel !== rs && n < 100) begin
      tick;
      n++;
    end
    if (n >= 100) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  // Default instance monitor: one-hot, blank gap between rows, frame period, drive scoreboard.
  logic [7:0] prev_rs = 8'h00;
  int cyc = 0;
  int last_fd = -1;
  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (!reset) last_fd = -1;
      else if (frame_done === 1'b1) begin
        if (last_fd >= 0) chk("frame_period", 64'(cyc - last_fd), 64'd40);
        last_fd = cyc;
      end
      chk("onehot", 64'($countones(row_sel) <= 1), 64'd1);
      if (row_sel !== 8'h00) begin
        if (prev_rs !== 8'h00 && prev_rs !== row_sel) chk("blank_gap", 64'(prev_rs), 64'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL drive_unexpected row_sel=%h col=%h required no drive", row_sel, col_data);
        end else begin
          chk("drive", 64'({row_sel, col_data}), 64'(exp_q.pop_front()));
        end
      end
      prev_rs = row_sel;
    end
  end

  // Active-low / no-blank instance monitor.
  int cyc2 = 0;
  int last_fd2 = -1;
  always @(negedge clk) begin
    if (mon_en) begin
      cyc2++;
      if (!reset2) last_fd2 = -1;
      else if (frame_done2 === 1'b1) begin
        if (last_fd2 >= 0) chk("frame_period2", 64'(cyc2 - last_fd2), 64'd32);
        last_fd2 = cyc2;
      end
      chk("onehot2", 64'($countones(row_sel2) <= 1), 64'd1);
      if (busy2 === 1'b1 && row_sel2 === 8'h00) chk("no_gap2", 64'(row_sel2), 64'd1);
      if (row_sel2 !== 8'h00) begin
        if (exp_q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL drive2_unexpected row_sel=%h col=%h required no drive", row_sel2, col_data2);
        end else begin
          chk("drive2", 64'({row_sel2, col_data2}), 64'(exp_q2.pop_front()));
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1'b0; frame_valid = 1'b0; frame_in = 64'd0;
    reset2 = 1'b0; frame_valid2 = 1'b0; frame_in2 = 64'd0;
    repeat (3) tick;
    mon_en = 1'b1;

    // Reset state
    chk("rst_row_sel", 64'(row_sel), 64'h00);
    chk("rst_col", 64'(col_data), 64'h00);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(frame_ready), 64'd1);
    chk("rst_done", 64'(frame_done), 64'd0);
    chk("rst2_col", 64'(col_data2), 64'hFF);
    chk("rst2_ready", 64'(frame_ready2), 64'd1);

    reset = 1'b1;
    tick;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_row_sel", 64'(row_sel), 64'h00);

    // Load from IDLE: two frames of the first board expected
    frame_in = 64'h0412_6424_0034_3C28;
    frame_valid = 1'b1;
    push_frame(64'h283C_3400_2464_1204, 1'b0, 1'b0);
    push_frame(64'h283C_3400_2464_1204, 1'b0, 1'b0);
    tick;
    chk("accept_ready", 64'(frame_ready), 64'd0);
    frame_valid = 1'b0;
    frame_in = 64'hA5A5_A5A5_A5A5_A5A5;
    tick;
    chk("swap_ready", 64'(frame_ready), 64'd1);
    chk("swap_busy", 64'(busy), 64'd1);
    chk("swap_row_sel", 64'(row_sel), 64'h00);
    tick;
    chk("first_row_sel", 64'(row_sel), 64'h01);
    chk("first_col", 64'(col_data), 64'h28);

    // Mid-frame load during row 3 of frame 2
    wait_fd(1'b0, "fd1");
    wait_row(8'h08, "row3");
    frame_in = 64'hFFFF_FFFF_FFFF_FFFF;
    frame_valid = 1'b1;
    push_frame(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    tick;
    chk("midload_ready", 64'(frame_ready), 64'd0);
    frame_valid = 1'b0;
    wait_fd(1'b0, "fd2");
    chk("swap2_ready", 64'(frame_ready), 64'd1);

    // Back-to-back offers: second held while pending is full
    frame_in = 64'h8040_2010_0804_0201;
    frame_valid = 1'b1;
    push_frame(64'h0102_0408_1020_4080, 1'b0, 1'b0);
    push_frame(64'h8040_2010_0804_0201, 1'b0, 1'b0);
    tick;
    chk("f3_accept_ready", 64'(frame_ready), 64'd0);
    frame_in = 64'h0102_0408_1020_4080;
    n = 0;
    tick;
    while (frame_done !== 1'b1 && n < 100) begin
      chk("hold_ready", 64'(frame_ready), 64'd0);
      tick;
      n++;
    end
    if (n >= 100) chk("fd3_timeout", 64'd0, 64'd1);
    chk("f3_swap_ready", 64'(frame_ready), 64'd1);
    tick;
    chk("f4_accept_ready", 64'(frame_ready), 64'd0);
    frame_valid = 1'b0;
    wait_fd(1'b0, "fd4");
    chk("f4_swap_ready", 64'(frame_ready), 64'd1);

    // Reset in row 5 with a pending board that must never appear
    frame_in = 64'hDEAD_BEEF_0000_0000;
    frame_valid = 1'b1;
    tick;
    chk("f5_accept_ready", 64'(frame_ready), 64'd0);
    frame_valid = 1'b0;
    wait_row(8'h20, "row5");
    reset = 1'b0;
    tick;
    chk("mid_rst_row_sel", 64'(row_sel), 64'h00);
    chk("mid_rst_col", 64'(col_data), 64'h00);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(frame_ready), 64'd1);
    chk("mid_rst_done", 64'(frame_done), 64'd0);
    chk("drives_left", 64'(exp_q.size()), 64'd11);
    exp_q.delete();
    tick;
    reset = 1'b1;
    repeat (60) tick;
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_row_sel", 64'(row_sel), 64'h00);

    // Active-low columns, no blanking
    reset2 = 1'b1;
    tick;
    chk("idle2_col", 64'(col_data2), 64'hFF);
    chk("idle2_row_sel", 64'(row_sel2), 64'h00);
    frame_in2 = 64'h0412_6424_0034_3C28;
    frame_valid2 = 1'b1;
    for (int f = 0; f < 3; f++) push_frame(64'h283C_3400_2464_1204, 1'b1, 1'b1);
    tick;
    chk("accept2_ready", 64'(frame_ready2), 64'd0);
    frame_valid2 = 1'b0;
    tick;
    chk("first2_row_sel", 64'(row_sel2), 64'h01);
    chk("first2_col", 64'(col_data2), 64'hD7);
    chk("swap2b_ready", 64'(frame_ready2), 64'd1);
    wait_fd(1'b1, "fd2a");
    wait_fd(1'b1, "fd2b");
    reset2 = 1'b0;
    tick;
    chk("rst2b_col", 64'(col_data2), 64'hFF);
    chk("rst2b_row_sel", 64'(row_sel2), 64'h00);
    chk("drives2_left", 64'(exp_q2.size()), 64'd31);
    exp_q2.delete();
    repeat (2) tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
